wb_stage: RTL and testbench

- MEM/WB pipeline register and writeback driver for the pipelined MIPS core.
- Captures the memory-stage result on posedge and applies load byte/halfword extraction and sign/zero extension.
- Drives the register file write port: control_reg_write, control_write_id, reg_write_value.
- All write-port outputs are registered and change only at posedge, so they are stable across the register file's negedge write.

---
 rtl/wb_stage_pkg.sv | 11 +
 rtl/wb_stage_load_aligner.sv | 30 +++
 rtl/wb_stage.sv | 103 ++++++++++
 tb/tb_wb_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared writeback definitions (load-size encodings, zero register id).
package wb_stage_pkg;
    typedef enum logic [1:0] {
        LOAD_WORD = 2'b00,
        LOAD_HALF = 2'b01,
        LOAD_BYTE = 2'b10,
        LOAD_RSVD = 2'b11
    } load_size_e;

    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/wb_stage_load_aligner.sv
// load_aligner: little-endian byte/halfword extraction with sign/zero extension.
// Ports: read_data (raw memory word), load_size (word/half/byte), load_unsigned
// (zero-extend when 1), byte_offset (address [1:0]) -> value (extended result),
// misaligned (half at odd offset or word at nonzero offset).
module load_aligner
    import wb_stage_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  load_size,
    input  logic        load_unsigned,
    input  logic [1:0]  byte_offset,
    output logic [31:0] value,
    output logic        misaligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_word;

    assign byte_sel = byte_offset == 2'd0 ? read_data[7:0]   :
                      byte_offset == 2'd1 ? read_data[15:8]  :
                      byte_offset == 2'd2 ? read_data[23:16] : read_data[31:24];
    assign half_sel = byte_offset[1] ? read_data[31:16] : read_data[15:0];
    // The reserved size encoding behaves as a word load.
    assign is_word  = load_size == LOAD_WORD || load_size == LOAD_RSVD;

    assign value = load_size == LOAD_BYTE ? {{24{~load_unsigned & byte_sel[7]}}, byte_sel} :
                   load_size == LOAD_HALF ? {{16{~load_unsigned & half_sel[15]}}, half_sel} :
                   read_data;
    assign misaligned = (load_size == LOAD_HALF && byte_offset[0]) || (is_word && byte_offset != 2'd0);
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and register-file writeback driver.
// Ports: clock, reset_n (synchronous, active-low), stall (hold), flush (bubble),
// mem_* (memory-stage instruction fields), control_reg_write / control_write_id /
// reg_write_value (registered register-file write port), misaligned_load
// (one-cycle pulse), retire_count (retired-instruction counter).
// Option: define WB_RETIRE_COUNT_EN to build the retire counter; otherwise
// retire_count is tied to 0.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    mem_valid,
    input  logic                    mem_reg_write,
    input  logic                    mem_mem_to_reg,
    input  logic [1:0]              mem_load_size,
    input  logic                    mem_load_unsigned,
    input  logic [1:0]              mem_byte_offset,
    input  logic [REG_ID_WIDTH-1:0] mem_write_id,
    input  logic [DATA_WIDTH-1:0]   mem_alu_result,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    output logic                    control_reg_write,
    output logic [REG_ID_WIDTH-1:0] control_write_id,
    output logic [DATA_WIDTH-1:0]   reg_write_value,
    output logic                    misaligned_load,
    output logic [31:0]             retire_count
);
    logic                    valid_q, valid_d;
    logic                    wr_q, wr_d;
    logic [REG_ID_WIDTH-1:0] id_q, id_d;
    logic [DATA_WIDTH-1:0]   value_q, value_d;
    logic                    mis_q, mis_d;
    logic [DATA_WIDTH-1:0]   load_value;
    logic                    load_mis;
    logic                    capture;
    logic                    mis;

    load_aligner u_aligner (
        .read_data     (mem_read_data),
        .load_size     (mem_load_size),
        .load_unsigned (mem_load_unsigned),
        .byte_offset   (mem_byte_offset),
        .value         (load_value),
        .misaligned    (load_mis)
    );

    assign capture = !flush && !stall;
    // Alignment only matters when the load data is actually selected.
    assign mis     = mem_valid && mem_mem_to_reg && load_mis;

    always_comb begin
        valid_d = flush ? 1'b0 : capture ? mem_valid : valid_q;
        wr_d    = flush ? 1'b0 : capture ? mem_valid && mem_reg_write && !mis &&
                  mem_write_id != REG_ID_WIDTH'(ZERO_REG) : wr_q;
        id_d    = capture ? mem_write_id : id_q;
        value_d = capture ? (mem_mem_to_reg ? load_value : mem_alu_result) : value_q;
        // Stall and flush drop the pulse so it is never repeated.
        mis_d   = capture && mis;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            id_q    <= '0;
            value_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            id_q    <= id_d;
            value_q <= value_d;
            mis_q   <= mis_d;
        end
    end

    // Write only from a live slot; wr_q already implies valid, this keeps it explicit.
    assign control_reg_write = wr_q && valid_q;
    assign control_write_id  = id_q;
    assign reg_write_value   = value_q;
    assign misaligned_load   = mis_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_q, retire_d;

    // Every real instruction retires, including non-writing and misaligned ones.
    assign retire_d = retire_q + 32'(capture && mem_valid);

    always_ff @(posedge clock) begin
        if (!reset_n) retire_q <= '0;
        else retire_q <= retire_d;
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage.
module tb_wb_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic        mem_mem_to_reg = 1'b0;
    logic [1:0]  mem_load_size = 2'b00;
    logic        mem_load_unsigned = 1'b0;
    logic [1:0]  mem_byte_offset = 2'b00;
    logic [4:0]  mem_write_id = 5'd0;
    logic [31:0] mem_alu_result = 32'd0;
    logic [31:0] mem_read_data = 32'd0;
    logic        control_reg_write;
    logic [4:0]  control_write_id;
    logic [31:0] reg_write_value;
    logic        misaligned_load;
    logic [31:0] retire_count;

    typedef struct {
        logic        wr;
        logic [4:0]  id;
        logic [31:0] val;
        logic        val_care;
        logic        mis;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;

    wb_stage dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .stall             (stall),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_to_reg    (mem_mem_to_reg),
        .mem_load_size     (mem_load_size),
        .mem_load_unsigned (mem_load_unsigned),
        .mem_byte_offset   (mem_byte_offset),
        .mem_write_id      (mem_write_id),
        .mem_alu_result    (mem_alu_result),
        .mem_read_data     (mem_read_data),
        .control_reg_write (control_reg_write),
        .control_write_id  (control_write_id),
        .reg_write_value   (reg_write_value),
        .misaligned_load   (misaligned_load),
        .retire_count      (retire_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] off);
        logic [31:0] s;
        s = rd >> (8 * off);
        case (sz)
            2'b10: return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'b01: return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic step(input string tag, input logic v, input logic rw, input logic m2r,
                        input logic [1:0] sz, input logic uns, input logic [1:0] off,
                        input logic [4:0] id, input logic [31:0] alu, input logic [31:0] rd,
                        input logic st, input logic fl);
        logic mis;
        exp_t e;
        mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_load_size = sz;
        mem_load_unsigned = uns; mem_byte_offset = off; mem_write_id = id;
        mem_alu_result = alu; mem_read_data = rd; stall = st; flush = fl;
        mis = v && m2r && ((sz == 2'b01 && off[0]) || ((sz == 2'b00 || sz == 2'b11) && off != 2'b00));
        if (!reset_n) begin
            m = '{wr: 1'b0, id: 5'd0, val: 32'd0, val_care: 1'b1, mis: 1'b0, ret: 32'd0};
        end else if (fl) begin
            m.wr = 1'b0;
            m.mis = 1'b0;
        end else if (st) begin
            m.mis = 1'b0;
        end else begin
            m.wr = v && rw && id != 5'd0 && !mis;
            m.id = id;
            m.val = m2r ? model_load(rd, sz, uns, off) : alu;
            m.val_care = !mis;
            m.mis = mis;
`ifdef WB_RETIRE_COUNT_EN
            if (v) m.ret = m.ret + 32'd1;
`endif
        end
        sb.push_back(m);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({tag, ".wr"}, {31'd0, control_reg_write}, {31'd0, e.wr});
        if (e.wr) check({tag, ".id"}, {27'd0, control_write_id}, {27'd0, e.id});
        if (e.val_care) check({tag, ".val"}, reg_write_value, e.val);
        check({tag, ".mis"}, {31'd0, misaligned_load}, {31'd0, e.mis});
        check({tag, ".ret"}, retire_count, e.ret);
    endtask

    initial begin
        m = '{wr: 1'b0, id: 5'd0, val: 32'd0, val_care: 1'b1, mis: 1'b0, ret: 32'd0};
        reset_n = 1'b0;
        step("rst0", 1, 1, 0, 2'b00, 0, 2'd0, 5'd8, 32'hDEAD_BEEF, 32'h0, 0, 0);
        step("rst1", 1, 1, 1, 2'b01, 0, 2'd1, 5'd8, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0);
        check("rst.id", {27'd0, control_write_id}, 32'd0);
        reset_n = 1'b1;
        step("first", 1, 1, 0, 2'b00, 0, 2'd0, 5'd3, 32'h0000_0011, 32'h0, 0, 0);
        step("lb",    1, 1, 1, 2'b10, 0, 2'd3, 5'd8, 32'h0, 32'h80FF_7F01, 0, 0);
        step("lbu",   1, 1, 1, 2'b10, 1, 2'd3, 5'd8, 32'h0, 32'h80FF_7F01, 0, 0);
        step("lb2",   1, 1, 1, 2'b10, 0, 2'd2, 5'd8, 32'h0, 32'h80FF_7F01, 0, 0);
        step("lb1",   1, 1, 1, 2'b10, 0, 2'd1, 5'd7, 32'h0, 32'h80FF_7F01, 0, 0);
        step("lh",    1, 1, 1, 2'b01, 0, 2'd2, 5'd4, 32'h0, 32'h8001_9234, 0, 0);
        step("lhu0",  1, 1, 1, 2'b01, 1, 2'd0, 5'd4, 32'h0, 32'h8001_9234, 0, 0);
        step("lh0",   1, 1, 1, 2'b01, 0, 2'd0, 5'd5, 32'h0, 32'h8001_9234, 0, 0);
        step("lhmis", 1, 1, 1, 2'b01, 0, 2'd1, 5'd8, 32'h0, 32'h8001_9234, 0, 0);
        step("lw",    1, 1, 1, 2'b00, 0, 2'd0, 5'd6, 32'h0, 32'hCAFE_BABE, 0, 0);
        step("lwmis", 1, 1, 1, 2'b00, 0, 2'd2, 5'd6, 32'h0, 32'hCAFE_BABE, 0, 0);
        step("misst", 1, 1, 0, 2'b00, 0, 2'd0, 5'd6, 32'h1, 32'h0, 1, 0);
        step("lrsv",  1, 1, 1, 2'b11, 0, 2'd0, 5'd10, 32'h0, 32'h1357_9BDF, 0, 0);
        step("aluof", 1, 1, 0, 2'b00, 0, 2'd3, 5'd11, 32'h0000_ABCD, 32'h0, 0, 0);
        step("inval", 0, 1, 0, 2'b00, 0, 2'd0, 5'd12, 32'h0000_0042, 32'h0, 0, 0);
        step("zero",  1, 1, 0, 2'b00, 0, 2'd0, 5'd0, 32'h0000_1234, 32'h0, 0, 0);
        step("alu",   1, 1, 0, 2'b00, 0, 2'd0, 5'd2, 32'h0000_1234, 32'h0, 0, 0);
        step("norw",  1, 0, 0, 2'b00, 0, 2'd0, 5'd13, 32'h0000_0777, 32'h0, 0, 0);
        step("cap9",  1, 1, 0, 2'b00, 0, 2'd0, 5'd9, 32'h0000_0005, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, 1, 2'b10, 1, 2'd1, 5'd20, 32'h77, 32'h1234_5678, 1, 0);
        step("stfl",  1, 1, 0, 2'b00, 0, 2'd0, 5'd21, 32'h99, 32'h0, 1, 1);
        step("fl",    1, 1, 0, 2'b00, 0, 2'd0, 5'd22, 32'h98, 32'h0, 0, 1);
        step("after", 1, 1, 0, 2'b00, 0, 2'd0, 5'd23, 32'h0000_5A5A, 32'h0, 0, 0);
`ifdef WB_RETIRE_COUNT_EN
        force dut.retire_q = 32'hFFFF_FFFF;
        m.ret = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        step("wrap",  1, 1, 0, 2'b00, 0, 2'd0, 5'd24, 32'h1, 32'h0, 0, 0);
        step("wrap1", 1, 1, 0, 2'b00, 0, 2'd0, 5'd25, 32'h2, 32'h0, 0, 0);
`endif
        reset_n = 1'b0;
        step("rst2",  1, 1, 0, 2'b00, 0, 2'd0, 5'd26, 32'h3, 32'h0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
